// File: rtl/mv_best_select.sv
// mv_best_select
// Tracks, per partition lane, the minimum SAD and the motion vector at which
// it occurred across one search window, and publishes the winners with a
// one-cycle valid pulse.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 begin (or abort and restart) a search window
//   sad_valid, sad_last   candidate strobe / final-candidate qualifier
//   search_column_count   candidate column position
//   search_row_count      candidate row position
//   sad_bus               LANES packed SAD values, lane i at [i*SAD_W +: SAD_W]
//   best_sad              published minimum SAD per lane (same packing)
//   best_mv_x, best_mv_y  published MV components per lane (count - RANGE)
//   cand_cnt              candidates accepted in the published window
//   result_valid          one-cycle pulse when the published set updates
//   busy                  high while a window is being searched
module mv_best_select #(
    parameter int LANES = 7,
    parameter int SAD_W = 16,
    parameter int CNT_W = 6,
    parameter int RANGE = 32,
    parameter int MV_W  = CNT_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sad_valid,
    input  logic                     sad_last,
    input  logic [CNT_W-1:0]         search_column_count,
    input  logic [CNT_W-1:0]         search_row_count,
    input  logic [LANES*SAD_W-1:0]   sad_bus,
    output logic [LANES*SAD_W-1:0]   best_sad,
    output logic [LANES*MV_W-1:0]    best_mv_x,
    output logic [LANES*MV_W-1:0]    best_mv_y,
    output logic [2*CNT_W:0]         cand_cnt,
    output logic                     result_valid,
    output logic                     busy
);

    localparam int CW = 2 * CNT_W + 1;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t state_q, state_d;

    logic [LANES-1:0][SAD_W-1:0] work_sad_q, work_sad_d;
    logic [LANES-1:0][MV_W-1:0]  work_mv_x_q, work_mv_x_d;
    logic [LANES-1:0][MV_W-1:0]  work_mv_y_q, work_mv_y_d;
    logic [CW-1:0]               work_cnt_q, work_cnt_d;

    logic [LANES-1:0][SAD_W-1:0] best_sad_q, best_sad_d;
    logic [LANES-1:0][MV_W-1:0]  best_mv_x_q, best_mv_x_d;
    logic [LANES-1:0][MV_W-1:0]  best_mv_y_q, best_mv_y_d;
    logic [CW-1:0]               cand_cnt_q, cand_cnt_d;
    logic                        result_valid_q, result_valid_d;

    logic                        accept;
    logic [MV_W-1:0]             cand_mv_x;
    logic [MV_W-1:0]             cand_mv_y;
    logic [SAD_W-1:0]            lane_sad;

    always_comb begin
        state_d        = state_q;
        work_sad_d     = work_sad_q;
        work_mv_x_d    = work_mv_x_q;
        work_mv_y_d    = work_mv_y_q;
        work_cnt_d     = work_cnt_q;
        best_sad_d     = best_sad_q;
        best_mv_x_d    = best_mv_x_q;
        best_mv_y_d    = best_mv_y_q;
        cand_cnt_d     = cand_cnt_q;
        result_valid_d = 1'b0;
        lane_sad       = '0;

        accept    = (state_q == SEARCH) && sad_valid;
        // Counts are zero-extended before the offset is removed.
        cand_mv_x = MV_W'(search_column_count) - MV_W'(RANGE);
        cand_mv_y = MV_W'(search_row_count) - MV_W'(RANGE);

        if (accept) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_sad = sad_bus[i*SAD_W +: SAD_W];
                // Strict compare: ties keep the earlier candidate.
                if (lane_sad < work_sad_q[i]) begin
                    work_sad_d[i]  = lane_sad;
                    work_mv_x_d[i] = cand_mv_x;
                    work_mv_y_d[i] = cand_mv_y;
                end
            end
            if (work_cnt_q != '1) begin
                work_cnt_d = work_cnt_q + CW'(1);
            end
        end

        // Publish takes the post-update working values so the last
        // candidate participates in the result.
        if (accept && sad_last) begin
            best_sad_d     = work_sad_d;
            best_mv_x_d    = work_mv_x_d;
            best_mv_y_d    = work_mv_y_d;
            cand_cnt_d     = work_cnt_d;
            result_valid_d = 1'b1;
            state_d        = IDLE;
        end

        // Start is applied after any publish so a coincident start opens a
        // fresh window instead of discarding the completing one.
        if (start) begin
            work_sad_d  = '1;
            work_mv_x_d = '0;
            work_mv_y_d = '0;
            work_cnt_d  = '0;
            state_d     = SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            work_sad_q     <= '1;
            work_mv_x_q    <= '0;
            work_mv_y_q    <= '0;
            work_cnt_q     <= '0;
            best_sad_q     <= '1;
            best_mv_x_q    <= '0;
            best_mv_y_q    <= '0;
            cand_cnt_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            work_sad_q     <= work_sad_d;
            work_mv_x_q    <= work_mv_x_d;
            work_mv_y_q    <= work_mv_y_d;
            work_cnt_q     <= work_cnt_d;
            best_sad_q     <= best_sad_d;
            best_mv_x_q    <= best_mv_x_d;
            best_mv_y_q    <= best_mv_y_d;
            cand_cnt_q     <= cand_cnt_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign best_sad     = best_sad_q;
    assign best_mv_x    = best_mv_x_q;
    assign best_mv_y    = best_mv_y_q;
    assign cand_cnt     = cand_cnt_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == SEARCH);

endmodule

// File: tb/tb_mv_best_select.sv
// Testbench for mv_best_select: directed scenarios plus randomized windows,
// checked against a queue-based reference of each window's candidates.
module tb_mv_best_select;

    localparam int L  = 7;
    localparam int SW = 16;
    localparam int MW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sad_valid;
    logic            sad_last;
    logic [5:0]      search_column_count;
    logic [5:0]      search_row_count;
    logic [L*SW-1:0] sad_bus;
    logic [L*SW-1:0] best_sad;
    logic [L*MW-1:0] best_mv_x;
    logic [L*MW-1:0] best_mv_y;
    logic [12:0]     cand_cnt;
    logic            result_valid;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0]      row;
        logic [5:0]      col;
        logic [L*SW-1:0] sad;
    } cand_t;

    cand_t       win[$];
    logic [15:0] exp_sad [L];
    logic [6:0]  exp_x   [L];
    logic [6:0]  exp_y   [L];
    logic [12:0] exp_cnt;

    mv_best_select #(
        .LANES(7),
        .SAD_W(16),
        .CNT_W(6),
        .RANGE(32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .sad_valid           (sad_valid),
        .sad_last            (sad_last),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count),
        .sad_bus             (sad_bus),
        .best_sad            (best_sad),
        .best_mv_x           (best_mv_x),
        .best_mv_y           (best_mv_y),
        .cand_cnt            (cand_cnt),
        .result_valid        (result_valid),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; rec records the candidate into the window model.
    task automatic send(input logic [5:0] r, input logic [5:0] c, input logic [L*SW-1:0] s,
                        input logic v, input logic l, input logic st, input bit rec);
        cand_t k;
        sad_valid           = v;
        sad_last            = l;
        start               = st;
        search_row_count    = r;
        search_column_count = c;
        sad_bus             = s;
        if (rec && v) begin
            k.row = r; k.col = c; k.sad = s;
            win.push_back(k);
        end
        cycle();
    endtask

    task automatic idle();
        send(6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic begin_win();
        win.delete();
        send(6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Reference: minimum per lane over the window in arrival order, first wins ties.
    task automatic compute_exp();
        for (int l = 0; l < L; l++) begin
            exp_sad[l] = 16'hFFFF;
            exp_x[l]   = '0;
            exp_y[l]   = '0;
        end
        foreach (win[k]) begin
            for (int l = 0; l < L; l++) begin
                if (win[k].sad[l*SW +: SW] < exp_sad[l]) begin
                    exp_sad[l] = win[k].sad[l*SW +: SW];
                    exp_x[l]   = 7'(int'(win[k].col) - 32);
                    exp_y[l]   = 7'(int'(win[k].row) - 32);
                end
            end
        end
        exp_cnt = (win.size() > 8191) ? 13'd8191 : 13'(win.size());
    endtask

    function automatic logic [L*SW-1:0] rand_bus(input int lo, input int hi);
        logic [L*SW-1:0] b;
        for (int l = 0; l < L; l++) b[l*SW +: SW] = 16'($urandom_range(hi, lo));
        return b;
    endfunction

    function automatic logic [L*SW-1:0] const_bus(input logic [15:0] v);
        logic [L*SW-1:0] b;
        for (int l = 0; l < L; l++) b[l*SW +: SW] = v;
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(); idle();
        rst = 1'b0;
        checks++; if (best_sad !== {L*SW{1'b1}}) begin failures++; $display("FAIL reset_best_sad got=%h exp=all ones", best_sad); end
        checks++; if (best_mv_x !== '0 || best_mv_y !== '0) begin failures++; $display("FAIL reset_mv got=%h/%h exp=0", best_mv_x, best_mv_y); end
        checks++; if (cand_cnt !== 13'd0 || result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctrl got cnt=%0d rv=%b busy=%b exp 0/0/0", cand_cnt, result_valid, busy); end
        // Candidates in IDLE are ignored.
        send(6'd1, 6'd2, const_bus(16'd3), 1'b1, 1'b0, 1'b0, 1'b0);
        send(6'd1, 6'd3, const_bus(16'd3), 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        checks++; if (cand_cnt !== 13'd0 || result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_ignore got cnt=%0d rv=%b busy=%b exp 0/0/0", cand_cnt, result_valid, busy); end
        // Reset mid-window discards everything.
        begin_win();
        for (int k = 0; k < 5; k++) send(6'(k), 6'(k), const_bus(16'd9), 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        send(6'd5, 6'd5, const_bus(16'd9), 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || cand_cnt !== 13'd0 || best_sad !== {L*SW{1'b1}}) begin failures++; $display("FAIL reset_midsearch got busy=%b rv=%b cnt=%0d sad=%h exp 0/0/0/all ones", busy, result_valid, cand_cnt, best_sad); end
        idle();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_no_publish got rv=%b exp 0", result_valid); end
    endtask

    task automatic test_single_min();
        begin_win();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                send(6'(r), 6'(c), const_bus((r == 40 && c == 20) ? 16'd5 : 16'd1000),
                     1'b1, (r == 63 && c == 63), 1'b0, 1'b1);
        checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_rv got rv=%b busy=%b exp 1/0", result_valid, busy); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== 16'd5 || best_mv_x[l*MW +: MW] !== 7'h74 || best_mv_y[l*MW +: MW] !== 7'h08) begin
                failures++;
                $display("FAIL single_lane%0d got sad=%0d x=%h y=%h exp sad=5 x=74 y=08", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW]);
            end
        end
        checks++; if (cand_cnt !== 13'd4096) begin failures++; $display("FAIL single_cnt got=%0d exp=4096", cand_cnt); end
        compute_exp();
        idle();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL rv_width got=%b exp=0", result_valid); end
    endtask

    task automatic test_tie();
        logic [L*SW-1:0] b;
        begin_win();
        for (int k = 0; k < 12; k++) begin
            b = rand_bus(10, 60000);
            b[0 +: SW]    = (k == 3 || k == 9) ? 16'd7 : 16'(100 + k);
            b[6*SW +: SW] = (k == 0 || k == 11) ? 16'd2 : 16'd50;
            if (k == 0)       send(6'd0, 6'd0, b, 1'b1, 1'b0, 1'b0, 1'b1);
            else if (k == 11) send(6'd63, 6'd63, b, 1'b1, 1'b1, 1'b0, 1'b1);
            else              send(6'(k), 6'(2 * k), b, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        compute_exp();
        checks++; if (result_valid !== 1'b1 || cand_cnt !== exp_cnt) begin failures++; $display("FAIL tie_ctrl got rv=%b cnt=%0d exp 1/%0d", result_valid, cand_cnt, exp_cnt); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== exp_sad[l] || best_mv_x[l*MW +: MW] !== exp_x[l] || best_mv_y[l*MW +: MW] !== exp_y[l]) begin
                failures++;
                $display("FAIL tie_lane%0d got %0d/%h/%h exp %0d/%h/%h", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW], exp_sad[l], exp_x[l], exp_y[l]);
            end
        end
        // Candidate 3 sits at row 3, col 6 -> (-26,-29); lane 6 keeps (0,0) -> (-32,-32).
        checks++; if (best_mv_x[0 +: MW] !== 7'h66 || best_mv_y[0 +: MW] !== 7'h63) begin failures++; $display("FAIL tie_lane0_first got x=%h y=%h exp x=66 y=63", best_mv_x[0 +: MW], best_mv_y[0 +: MW]); end
        checks++; if (best_mv_x[6*MW +: MW] !== 7'h60 || best_mv_y[6*MW +: MW] !== 7'h60) begin failures++; $display("FAIL tie_lane6_first got x=%h y=%h exp x=60 y=60", best_mv_x[6*MW +: MW], best_mv_y[6*MW +: MW]); end
        idle();
    endtask

    task automatic test_last_win();
        logic [L*SW-1:0] b;
        begin_win();
        for (int k = 0; k < 8; k++)
            send(6'($urandom_range(62)), 6'($urandom_range(62)), rand_bus(100, 60000), 1'b1, 1'b0, 1'b0, 1'b1);
        b = const_bus(16'hFFFF);
        b[2*SW +: SW] = 16'd0;
        send(6'd63, 6'd63, b, 1'b1, 1'b1, 1'b0, 1'b1);
        compute_exp();
        checks++; if (result_valid !== 1'b1 || cand_cnt !== 13'd9) begin failures++; $display("FAIL last_ctrl got rv=%b cnt=%0d exp 1/9", result_valid, cand_cnt); end
        checks++; if (best_sad[2*SW +: SW] !== 16'd0 || best_mv_x[2*MW +: MW] !== 7'h1F || best_mv_y[2*MW +: MW] !== 7'h1F) begin failures++; $display("FAIL last_lane2 got %0d/%h/%h exp 0/1f/1f", best_sad[2*SW +: SW], best_mv_x[2*MW +: MW], best_mv_y[2*MW +: MW]); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== exp_sad[l] || best_mv_x[l*MW +: MW] !== exp_x[l] || best_mv_y[l*MW +: MW] !== exp_y[l]) begin
                failures++;
                $display("FAIL last_lane%0d got %0d/%h/%h exp %0d/%h/%h", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW], exp_sad[l], exp_x[l], exp_y[l]);
            end
        end
        idle();
    endtask

    task automatic test_abort();
        logic [15:0] prev_sad [L];
        for (int l = 0; l < L; l++) prev_sad[l] = exp_sad[l];
        begin_win();
        for (int k = 0; k < 10; k++) send(6'(k), 6'(k + 3), const_bus(16'd1), 1'b1, 1'b0, 1'b0, 1'b1);
        send(6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        win.delete();
        checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL abort_ctrl got busy=%b rv=%b exp 1/0", busy, result_valid); end
        for (int l = 0; l < L; l++) begin
            checks++; if (best_sad[l*SW +: SW] !== prev_sad[l]) begin failures++; $display("FAIL abort_hold_lane%0d got=%0d exp=%0d", l, best_sad[l*SW +: SW], prev_sad[l]); end
        end
        send(6'd10, 6'd11, const_bus(16'd50), 1'b1, 1'b0, 1'b0, 1'b1);
        send(6'd12, 6'd13, const_bus(16'd40), 1'b1, 1'b0, 1'b0, 1'b1);
        send(6'd14, 6'd15, const_bus(16'd60), 1'b1, 1'b1, 1'b0, 1'b1);
        compute_exp();
        checks++; if (result_valid !== 1'b1 || cand_cnt !== 13'd3) begin failures++; $display("FAIL abort_pub got rv=%b cnt=%0d exp 1/3", result_valid, cand_cnt); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== 16'd40 || best_mv_x[l*MW +: MW] !== 7'h6D || best_mv_y[l*MW +: MW] !== 7'h6C) begin
                failures++;
                $display("FAIL abort_lane%0d got %0d/%h/%h exp 40/6d/6c", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW]);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        begin_win();
        send(6'd1, 6'd1, rand_bus(0, 99), 1'b1, 1'b0, 1'b0, 1'b1);
        send(6'd2, 6'd2, rand_bus(0, 99), 1'b1, 1'b0, 1'b0, 1'b1);
        send(6'd3, 6'd3, rand_bus(0, 99), 1'b1, 1'b1, 1'b1, 1'b1);
        compute_exp();
        win.delete();
        checks++; if (result_valid !== 1'b1 || busy !== 1'b1 || cand_cnt !== 13'd3) begin failures++; $display("FAIL b2b_first got rv=%b busy=%b cnt=%0d exp 1/1/3", result_valid, busy, cand_cnt); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== exp_sad[l] || best_mv_x[l*MW +: MW] !== exp_x[l] || best_mv_y[l*MW +: MW] !== exp_y[l]) begin
                failures++;
                $display("FAIL b2b_a_lane%0d got %0d/%h/%h exp %0d/%h/%h", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW], exp_sad[l], exp_x[l], exp_y[l]);
            end
        end
        send(6'd40, 6'd41, rand_bus(1000, 2000), 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL b2b_mid got busy=%b rv=%b exp 1/0", busy, result_valid); end
        send(6'd42, 6'd43, rand_bus(1000, 2000), 1'b1, 1'b1, 1'b0, 1'b1);
        compute_exp();
        checks++; if (result_valid !== 1'b1 || busy !== 1'b0 || cand_cnt !== 13'd2) begin failures++; $display("FAIL b2b_second got rv=%b busy=%b cnt=%0d exp 1/0/2", result_valid, busy, cand_cnt); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== exp_sad[l] || best_mv_x[l*MW +: MW] !== exp_x[l] || best_mv_y[l*MW +: MW] !== exp_y[l]) begin
                failures++;
                $display("FAIL b2b_b_lane%0d got %0d/%h/%h exp %0d/%h/%h", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW], exp_sad[l], exp_x[l], exp_y[l]);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        begin_win();
        for (int k = 0; k < 8200; k++)
            send(6'($urandom_range(63)), 6'($urandom_range(63)), rand_bus(0, 65535), 1'b1, (k == 8199), 1'b0, 1'b1);
        compute_exp();
        checks++; if (result_valid !== 1'b1 || cand_cnt !== 13'h1FFF) begin failures++; $display("FAIL sat_cnt got rv=%b cnt=%0d exp 1/8191", result_valid, cand_cnt); end
        for (int l = 0; l < L; l++) begin
            checks++;
            if (best_sad[l*SW +: SW] !== exp_sad[l] || best_mv_x[l*MW +: MW] !== exp_x[l] || best_mv_y[l*MW +: MW] !== exp_y[l]) begin
                failures++;
                $display("FAIL sat_lane%0d got %0d/%h/%h exp %0d/%h/%h", l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW], exp_sad[l], exp_x[l], exp_y[l]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        int n;
        for (int w = 0; w < 20; w++) begin
            begin_win();
            n = $urandom_range(30, 1);
            for (int k = 0; k < n; k++) begin
                // Gaps may carry a stray sad_last, which must be ignored.
                if ($urandom_range(3) == 0)
                    send(6'($urandom_range(63)), 6'($urandom_range(63)), rand_bus(0, 15), 1'b0, 1'($urandom_range(1)), 1'b0, 1'b1);
                send(6'($urandom_range(63)), 6'($urandom_range(63)), rand_bus(0, 15), 1'b1, (k == n - 1), 1'b0, 1'b1);
                if (k != n - 1) begin
                    checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rand_w%0d_mid got rv=%b busy=%b exp 0/1", w, result_valid, busy); end
                end
            end
            compute_exp();
            checks++; if (result_valid !== 1'b1 || cand_cnt !== exp_cnt) begin failures++; $display("FAIL rand_w%0d_pub got rv=%b cnt=%0d exp 1/%0d", w, result_valid, cand_cnt, exp_cnt); end
            for (int l = 0; l < L; l++) begin
                checks++;
                if (best_sad[l*SW +: SW] !== exp_sad[l] || best_mv_x[l*MW +: MW] !== exp_x[l] || best_mv_y[l*MW +: MW] !== exp_y[l]) begin
                    failures++;
                    $display("FAIL rand_w%0d_lane%0d got %0d/%h/%h exp %0d/%h/%h", w, l, best_sad[l*SW +: SW], best_mv_x[l*MW +: MW], best_mv_y[l*MW +: MW], exp_sad[l], exp_x[l], exp_y[l]);
                end
            end
            idle();
        end
    endtask

    initial begin
        rst                 = 1'b1;
        start               = 1'b0;
        sad_valid           = 1'b0;
        sad_last            = 1'b0;
        search_column_count = '0;
        search_row_count    = '0;
        sad_bus             = '0;
        test_reset();
        test_single_min();
        test_tie();
        test_last_win();
        test_abort();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
